decoder3x8_seq: RTL
===================

DECODER3X8_SEQ -- requirements
Module: decoder3x8_seq

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4: clock cycles each code is held in scan mode (legal range 1..255).
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port en, input, 1: global enable; when low, all state SHALL hold.
REQ-005 Port scan, input, 1: 1 = auto-scan mode, 0 = load mode.
REQ-006 Port code, input, 3: binary code to decode in load mode.
REQ-007 Port code_valid, input, 1: code is valid this cycle; sampled only in LOAD when en=1.
REQ-008 Port data, output, 8: registered one-hot decode of the current code.
REQ-009 Port data_valid, output, 1: data holds a decoded value.
REQ-010 Port cur_code, output, 3: code currently driving data.
REQ-011 Port wrap, output, 1: one-cycle pulse when the scan moves from code 7 to code 0.

Function
REQ-012 States SHALL be IDLE, LOAD and SCAN, with a 2-bit state register.
REQ-013 IDLE -> LOAD when en=1 and scan=0; IDLE -> SCAN when en=1 and scan=1; otherwise stay in IDLE.
REQ-014 LOAD -> SCAN when en=1 and scan=1; SCAN -> LOAD when en=1 and scan=0; the new mode takes effect on the following edge.
REQ-015 In LOAD with en=1 and code_valid=1: cur_code<=code, data<=(8'b1 << code) and data_valid<=1, giving 1-cycle latency.
REQ-016 In LOAD with code_valid=0, data, cur_code and data_valid SHALL hold their last values.
REQ-017 On entry to SCAN, cur_code<=0, data<=8'b0000_0001, data_valid<=1 and the divider counter<=0.
REQ-018 In SCAN with en=1, the 8-bit divider counter SHALL increment each cycle. When it reaches SCAN_DIV-1, it SHALL clear to 0 and cur_code SHALL advance by 1 modulo 8, with data updated to match on the same edge.
REQ-019 At the 7 -> 0 advance, wrap SHALL be 1 for exactly that cycle; wrap SHALL be 0 at all other times.
REQ-020 When SCAN_DIV=1, the code SHALL advance every enabled cycle.
REQ-021 data SHALL always equal one-hot(cur_code) when data_valid=1, and 8'h00 when data_valid=0.
REQ-022 When en=0 in any state, state, counter, data, cur_code and data_valid SHALL hold, and wrap SHALL be 0.
REQ-023 If scan changes in the same cycle that code_valid=1 in LOAD, the load SHALL still complete, and the mode change SHALL take effect on the next edge.
REQ-024 Leaving SCAN for LOAD SHALL retain the last scanned data until the next valid load.

Reset
REQ-025 When rst=1 at a clock edge, the next state SHALL be: state=IDLE, counter=0, data=8'h00, cur_code=3'b000, data_valid=0, wrap=0.
REQ-026 rst SHALL take priority over en, scan and code_valid.
REQ-027 Reset mid-scan or mid-load SHALL abort the operation with no residual pulse on wrap.

Verification
REQ-028 Hold rst=1 for 2 cycles, then release with en=0 -> data=8'h00, data_valid=0, cur_code=0, wrap=0, and state remains IDLE.
REQ-029 Set en=1, scan=0, then present code_valid=1 with code 0..7 in consecutive cycles -> data=8'b0000_0001 .. 8'b1000_0000 each one cycle after its code, cur_code matching.
REQ-030 In LOAD, load code=5 then drop code_valid for 10 cycles -> data stays 8'b0010_0000.
REQ-031 With SCAN_DIV=4, en=1, scan=1 -> data steps 01,02,04,...,80,01 every 4 cycles, and wrap pulses once per 32 cycles on the 80 -> 01 step.
REQ-032 While in SCAN at cur_code=3, set en=0 for 5 cycles, then en=1 -> the code remains 3 throughout and the divider resumes from its held count.
REQ-033 Assert rst during SCAN at cur_code=6 -> the next cycle gives data=8'h00, data_valid=0, wrap=0; after release, re-entering SCAN starts at code 0.

Source files
------------

// File: rtl/decoder3x8_seq.sv
// ---------------------------------------------------------------------------
// decoder3x8_seq
//
// Purpose:
//   Registered 3-to-8 one-hot decoder. It has two modes:
//   - LOAD: the decoded code comes from the code/code_valid inputs.
//   - SCAN: the block steps through codes 0..7 by itself. Each code is
//     held for SCAN_DIV cycles.
//
// Parameters:
//   SCAN_DIV   : cycles each code is held in scan mode (1..255)
//
// Ports:
//   clk        : in  clock; all state updates on the rising edge
//   rst        : in  synchronous active-high reset
//   en         : in  global enable; all state holds while low
//   scan       : in  1 = auto-scan mode, 0 = load mode
//   code       : in  [2:0] code to decode in load mode
//   code_valid : in  code is valid this cycle (sampled in LOAD only)
//   data       : out [7:0] registered one-hot decode of cur_code
//   data_valid : out data holds a decoded value
//   cur_code   : out [2:0] code currently driving data
//   wrap       : out one-cycle pulse on the scan step from code 7 to code 0
//
// State table:
//   IDLE | after reset; nothing decoded yet
//   LOAD | data follows code whenever code_valid is high
//   SCAN | cur_code advances every SCAN_DIV enabled cycles
// ---------------------------------------------------------------------------
module decoder3x8_seq #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       scan,
    input  logic [2:0] code,
    input  logic       code_valid,
    output logic [7:0] data,
    output logic       data_valid,
    output logic [2:0] cur_code,
    output logic       wrap
);

    generate
        if (SCAN_DIV < 1 || SCAN_DIV > 255) begin : g_bad_div
            $error("decoder3x8_seq: SCAN_DIV must be within 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // This is the terminal count of the divider. When the divider reaches
    // it, the divider clears and the code advances on the same edge.
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] next_code;

    assign next_code = cur_code + 3'd1;

    function automatic logic [7:0] onehot(input logic [2:0] c);
        onehot = 8'b0000_0001 << c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            data       <= 8'h00;
            cur_code   <= 3'd0;
            data_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            // wrap is a single-cycle pulse. It is cleared by default and
            // set only on the 7 -> 0 scan step.
            wrap <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (scan) begin
                            state      <= SCAN;
                            cnt        <= 8'd0;
                            cur_code   <= 3'd0;
                            data       <= 8'h01;
                            data_valid <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end

                    LOAD: begin
                        if (scan) begin
                            state <= SCAN;
                            cnt   <= 8'd0;
                        end
                        // A valid code presented on the same edge as the
                        // switch to scan still loads. In that case scanning
                        // continues from the loaded code. Without a valid
                        // code, entering scan restarts at code 0.
                        if (code_valid) begin
                            cur_code   <= code;
                            data       <= onehot(code);
                            data_valid <= 1'b1;
                        end else if (scan) begin
                            cur_code   <= 3'd0;
                            data       <= 8'h01;
                            data_valid <= 1'b1;
                        end
                    end

                    SCAN: begin
                        if (!scan) begin
                            // On the return to load, the last scanned value
                            // and the divider count are kept.
                            state <= LOAD;
                        end else if (cnt == DIV_LAST) begin
                            cnt      <= 8'd0;
                            cur_code <= next_code;
                            data     <= onehot(next_code);
                            wrap     <= (cur_code == 3'd7);
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
